uart_packetizer: RTL and testbench

UART_PACKETIZER -- requirements
Module: uart_packetizer

---
 rtl/uart_packetizer_pkg.sv | 38 +++
 rtl/uart_packetizer_payload_buf.sv | 28 ++
 rtl/uart_packetizer.sv | 171 +++++++++++++++++
 tb/tb_uart_packetizer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_packetizer_pkg.sv
// Shared constants, state encoding and check-byte update for uart_packetizer.
// Define UART_PACKETIZER_CRC8_EN to switch the check byte from additive sum to CRC-8.
package uart_packetizer_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef UART_PACKETIZER_CRC8_EN
  localparam bit CHK_IS_CRC8 = 1'b1;
`else
  localparam bit CHK_IS_CRC8 = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SYNC,
    S_ROWH,
    S_ROWL,
    S_LEN,
    S_PAY,
    S_CHK
  } pkt_state_e;

  // Folds one covered byte into the running check value.
  // CRC-8 is MSB first, init 0, no final XOR.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] din);
    logic [7:0] crc;
    logic [7:0] sum;
    crc = acc ^ din;
    for (int i = 0; i < 8; i++) begin
      crc = crc[7] ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
    end
    sum = acc + din;
    return CHK_IS_CRC8 ? crc : sum;
  endfunction

endpackage

// File: rtl/uart_packetizer_payload_buf.sv
// pkt_payload_buf: Depth x 8 simple dual-port RAM, synchronous write, registered read.
// Contents carry no reset; the packetizer never reads a location it has not written.
module pkt_payload_buf
  import uart_packetizer_pkg::*;
#(
  parameter int Depth = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [Depth];
  logic [7:0] r_rd_data;

  // Write port plus one-cycle registered read port.
  always_ff @(posedge CLK) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_packetizer.sv
// uart_packetizer: gathers FIFO bytes into packets
//   A5, ROW_HI, ROW_LO, LEN, payload[LEN], CHK
// and hands them to the UART one byte per take.
// Build option: UART_PACKETIZER_CRC8_EN selects CRC-8 check byte (default: 8-bit sum).
module uart_packetizer
  import uart_packetizer_pkg::*;
#(
  parameter int MaxPayload = 64,
  parameter int RowWidth   = 9
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          i_data,
  input  logic                i_empty,
  output logic                o_rd_en,
  input  logic [RowWidth-1:0] i_row_y,
  input  logic                i_row_end,
  output logic [7:0]          o_frame,
  output logic                o_valid,
  input  logic                i_take,
  output logic                o_busy,
  output logic                o_pkt_done
);

  localparam int CW = $clog2(MaxPayload + 1);
  localparam int AW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MaxPayload);

  pkt_state_e          r_state, w_state_nxt;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [CW-1:0]       r_pay_idx, w_pay_idx_nxt;
  logic [CW-1:0]       w_rd_next;
  logic                r_flush, w_flush_clr;
  logic [7:0]          r_chk, w_chk_nxt;
  logic [7:0]          w_frame, w_rd_data;
  logic [RowWidth-1:0] r_row;
  logic [15:0]         w_row16;
  logic [AW-1:0]       w_rd_addr, w_wr_addr;
  logic                w_rd_en, w_valid, w_done;

  assign w_row16   = 16'(r_row);
  assign w_wr_addr = r_count[AW-1:0];

  // Read address runs one byte ahead on a take so PAY streams without bubbles.
  always_comb begin
    w_rd_next = '0;
    if (r_state == S_PAY) w_rd_next = i_take ? (r_pay_idx + 1'b1) : r_pay_idx;
  end

  assign w_rd_addr = (w_rd_next < FULL_CNT) ? w_rd_next[AW-1:0] : '0;

  pkt_payload_buf #(
    .Depth(MaxPayload),
    .AW   (AW)
  ) u_buf (
    .CLK      (CLK),
    .i_wr_en  (w_rd_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(i_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  // Next-state, FIFO read strobe, output byte and check accumulation.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pay_idx_nxt = r_pay_idx;
    w_chk_nxt     = r_chk;
    w_flush_clr   = 1'b0;
    w_rd_en       = 1'b0;
    w_valid       = 1'b0;
    w_done        = 1'b0;
    w_frame       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (r_flush && i_empty) w_flush_clr = 1'b1;
        else if (!i_empty)      w_state_nxt = S_FILL;
      end
      S_FILL: begin
        w_rd_en = !i_empty && (r_count < FULL_CNT);
        if (w_rd_en) w_count_nxt = r_count + 1'b1;
        // Full takes priority and leaves a pending flush for the next packet.
        if (r_count == FULL_CNT) begin
          w_state_nxt = S_SYNC;
        end else if (r_flush && i_empty) begin
          w_flush_clr = 1'b1;
          w_state_nxt = (r_count != '0) ? S_SYNC : S_IDLE;
        end
      end
      S_SYNC: begin
        w_valid = 1'b1;
        w_frame = SYNC_BYTE;
        if (i_take) begin
          w_chk_nxt   = 8'h00;
          w_state_nxt = S_ROWH;
        end
      end
      S_ROWH: begin
        w_valid = 1'b1;
        w_frame = w_row16[15:8];
        if (i_take) begin
          w_chk_nxt   = chk_update(r_chk, w_frame);
          w_state_nxt = S_ROWL;
        end
      end
      S_ROWL: begin
        w_valid = 1'b1;
        w_frame = w_row16[7:0];
        if (i_take) begin
          w_chk_nxt   = chk_update(r_chk, w_frame);
          w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        w_valid = 1'b1;
        w_frame = 8'(r_count);
        if (i_take) begin
          w_chk_nxt     = chk_update(r_chk, w_frame);
          w_pay_idx_nxt = '0;
          w_state_nxt   = S_PAY;
        end
      end
      S_PAY: begin
        w_valid = 1'b1;
        w_frame = w_rd_data;
        if (i_take) begin
          w_chk_nxt     = chk_update(r_chk, w_frame);
          w_pay_idx_nxt = r_pay_idx + 1'b1;
          if (r_pay_idx == (r_count - 1'b1)) w_state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        w_valid = 1'b1;
        w_frame = r_chk;
        if (i_take) begin
          w_done      = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = i_empty ? S_IDLE : S_FILL;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, flush flag, check accumulator and latched row.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_pay_idx <= '0;
      r_flush   <= 1'b0;
      r_chk     <= 8'h00;
      r_row     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pay_idx <= w_pay_idx_nxt;
      r_flush   <= (r_flush & ~w_flush_clr) | i_row_end;
      r_chk     <= w_chk_nxt;
      if (w_rd_en && (r_count == '0)) r_row <= i_row_y;
    end
  end

  assign o_rd_en    = w_rd_en;
  assign o_valid    = w_valid;
  assign o_frame    = w_frame;
  assign o_pkt_done = w_done;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_packetizer.sv
// Directed self-checking bench for uart_packetizer (MaxPayload=64, RowWidth=9).
module tb_uart_packetizer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_empty = 1'b1;
  logic       o_rd_en;
  logic [8:0] i_row_y = '0;
  logic       i_row_end = 1'b0;
  logic [7:0] o_frame;
  logic       o_valid;
  logic       i_take = 1'b0;
  logic       o_busy;
  logic       o_pkt_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];

  uart_packetizer #(.MaxPayload(64), .RowWidth(9)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_data    (i_data),
    .i_empty   (i_empty),
    .o_rd_en   (o_rd_en),
    .i_row_y   (i_row_y),
    .i_row_end (i_row_end),
    .o_frame   (o_frame),
    .o_valid   (o_valid),
    .i_take    (i_take),
    .o_busy    (o_busy),
    .o_pkt_done(o_pkt_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference check byte, written as a serial LFSR over data bits.
  function automatic logic [7:0] chk_model(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_PACKETIZER_CRC8_EN
    logic [7:0] c;
    logic fb;
    c = acc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
`else
    return 8'((int'(acc) + int'(b)) % 256);
`endif
  endfunction

  function automatic void add_pkt(input logic [15:0] row, input int first, input int len);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    b = row[15:8]; exp_q.push_back(b); c = chk_model(c, b);
    b = row[7:0];  exp_q.push_back(b); c = chk_model(c, b);
    b = 8'(len);   exp_q.push_back(b); c = chk_model(c, b);
    for (int i = 0; i < len; i++) begin
      b = pay_q[first + i];
      exp_q.push_back(b);
      c = chk_model(c, b);
    end
    exp_q.push_back(c);
  endfunction

  function automatic void fifo_refresh();
    i_empty = (fifo_q.size() == 0);
    i_data  = i_empty ? 8'h00 : fifo_q[0];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    pay_q.push_back(b);
    fifo_refresh();
  endtask

  // FWFT FIFO model: pop after an edge where the read strobe met a non-empty FIFO.
  initial begin
    bit pop_now;
    forever begin
      @(negedge CLK);
      pop_now = o_rd_en && !i_empty;
      @(posedge CLK);
      #1;
      if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_refresh();
    end
  end

  // Byte and packet-done monitor.
  always @(negedge CLK) begin
    if (o_valid && i_take) out_q.push_back(o_frame);
    if (o_pkt_done) done_cnt++;
  end

  task automatic start_test();
    out_q.delete();
    exp_q.delete();
    pay_q.delete();
    done_base = done_cnt;
  endtask

  task automatic wait_out(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (out_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_row_end();
    @(posedge CLK); #1;
    i_row_end = 1'b1;
    @(posedge CLK); #1;
    i_row_end = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (o_valid !== 1'b0)    begin errors++; $display("FAIL reset o_valid: got %b need 0", o_valid); end
    checks++; if (o_frame !== 8'h00)   begin errors++; $display("FAIL reset o_frame: got %h need 00", o_frame); end
    checks++; if (o_rd_en !== 1'b0)    begin errors++; $display("FAIL reset o_rd_en: got %b need 0", o_rd_en); end
    checks++; if (o_busy !== 1'b0)     begin errors++; $display("FAIL reset o_busy: got %b need 0", o_busy); end
    checks++; if (o_pkt_done !== 1'b0) begin errors++; $display("FAIL reset o_pkt_done: got %b need 0", o_pkt_done); end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset o_busy: got %b need 0", o_busy); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] c;
    start_test();
    i_row_y = 9'd5;
    i_take  = 1'b1;
    @(posedge CLK); #1;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    i_row_end = 1'b1;
    @(posedge CLK); #1;
    i_row_end = 1'b0;
    wait_out(8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic timeout: got %0d bytes need 8", out_q.size()); end
    exp_q = '{8'hA5, 8'h00, 8'h05, 8'h03, 8'h01, 8'h02, 8'h03};
    c = 8'h00;
    for (int i = 1; i < 7; i++) c = chk_model(c, exp_q[i]);
    exp_q.push_back(c);
    repeat (5) @(negedge CLK);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL basic byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL basic count: got %0d need 8", out_q.size()); end
    checks++; if (done_cnt - done_base != 1) begin errors++; $display("FAIL basic pkt_done: got %0d need 1", done_cnt - done_base); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic idle: got busy %b need 0", o_busy); end
  endtask

  task automatic test_full();
    bit ok;
    start_test();
    i_row_y = 9'd7;
    i_take  = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 130; i++) push_byte(8'((i * 7 + 16) % 256));
    wait_out(138, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full timeout: got %0d bytes need 138", out_q.size()); end
    repeat (20) @(negedge CLK);
    checks++; if (out_q.size() != 138) begin errors++; $display("FAIL full hold count: got %0d need 138", out_q.size()); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL full hold busy: got %b need 1", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full hold valid: got %b need 0", o_valid); end
    checks++; if (fifo_q.size() != 0) begin errors++; $display("FAIL full leftover read: fifo holds %0d need 0", fifo_q.size()); end
    i_row_y = 9'd9;
    pulse_row_end();
    wait_out(145, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full tail timeout: got %0d bytes need 145", out_q.size()); end
    add_pkt(16'd7, 0, 64);
    add_pkt(16'd7, 64, 64);
    add_pkt(16'd7, 128, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL full byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL full byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - done_base != 3) begin errors++; $display("FAIL full pkt_done: got %0d need 3", done_cnt - done_base); end
  endtask

  task automatic test_slow_take();
    bit prev_hold;
    logic [7:0] prev_frame;
    start_test();
    i_row_y = 9'd3;
    i_take  = 1'b0;
    @(posedge CLK); #1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    i_row_end = 1'b1;
    prev_hold = 1'b0;
    prev_frame = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge CLK); #1;
      i_row_end = 1'b0;
      i_take = (cyc % 7 == 6);
      @(negedge CLK);
      if (prev_hold) begin
        checks++;
        if (o_valid !== 1'b1 || o_frame !== prev_frame) begin
          errors++;
          $display("FAIL slow hold: got valid %b frame %h need valid 1 frame %h", o_valid, o_frame, prev_frame);
        end
      end
      prev_hold  = o_valid && !i_take;
      prev_frame = o_frame;
      if (out_q.size() >= 10) break;
    end
    i_take = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (out_q.size() != 10) begin errors++; $display("FAIL slow count: got %0d need 10", out_q.size()); end
    add_pkt(16'd3, 0, 5);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL slow byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL slow byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - done_base != 1) begin errors++; $display("FAIL slow pkt_done: got %0d need 1", done_cnt - done_base); end
  endtask

  task automatic test_empty_flush();
    bit ok;
    bit seen_valid;
    start_test();
    i_row_y = 9'h1AB;
    i_take  = 1'b1;
    pulse_row_end();
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (o_valid) seen_valid = 1'b1;
    end
    checks++; if (seen_valid) begin errors++; $display("FAIL empty_flush valid: got 1 need 0"); end
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL empty_flush bytes: got %0d need 0", out_q.size()); end
    @(posedge CLK); #1;
    push_byte(8'h66); push_byte(8'h77);
    repeat (15) @(negedge CLK);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL empty_flush stale flush: got %0d bytes need 0", out_q.size()); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL empty_flush fill busy: got %b need 1", o_busy); end
    pulse_row_end();
    wait_out(7, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_flush timeout: got %0d bytes need 7", out_q.size()); end
    add_pkt(16'h01AB, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL empty_flush byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL empty_flush byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_row_end_full();
    bit ok;
    bit found;
    start_test();
    i_row_y = 9'd2;
    i_take  = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 64; i++) push_byte(8'((i * 3 + 1) % 256));
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (o_rd_en && fifo_q.size() == 1) begin
        i_row_end = 1'b1;
        found = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
    i_row_end = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL row_end_full last read: got none need one"); end
    wait_out(69, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL row_end_full timeout: got %0d bytes need 69", out_q.size()); end
    add_pkt(16'd2, 0, 64);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL row_end_full byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL row_end_full byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
    repeat (20) @(negedge CLK);
    checks++; if (out_q.size() != 69) begin errors++; $display("FAIL row_end_full extra: got %0d bytes need 69", out_q.size()); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL row_end_full idle: got busy %b need 0", o_busy); end
    pulse_row_end();
    repeat (20) @(negedge CLK);
    checks++; if (out_q.size() != 69) begin errors++; $display("FAIL row_end_only flush: got %0d bytes need 69", out_q.size()); end
    checks++; if (done_cnt - done_base != 1) begin errors++; $display("FAIL row_end_full pkt_done: got %0d need 1", done_cnt - done_base); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_test();
    i_row_y = 9'd4;
    i_take  = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 64; i++) push_byte(8'(200 - i));
    wait_out(14, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_mid timeout: got %0d bytes need 14", out_q.size()); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL reset_mid in PAY: got valid %b need 1", o_valid); end
    #2;
    RST = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL reset_mid o_valid: got %b need 0", o_valid); end
    checks++; if (o_frame !== 8'h00) begin errors++; $display("FAIL reset_mid o_frame: got %h need 00", o_frame); end
    checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL reset_mid o_busy: got %b need 0", o_busy); end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    start_test();
    repeat (10) @(negedge CLK);
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL reset_mid remnant: got %0d bytes need 0", out_q.size()); end
    @(posedge CLK); #1;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    pulse_row_end();
    wait_out(8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_mid new pkt timeout: got %0d bytes need 8", out_q.size()); end
    checks++; if (out_q.size() == 0 || out_q[0] !== 8'hA5) begin errors++; $display("FAIL reset_mid first byte: got %h need a5", (out_q.size() == 0) ? 8'h00 : out_q[0]); end
    add_pkt(16'd4, 0, 3);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= out_q.size()) begin errors++; $display("FAIL reset_mid byte %0d: missing need %h", i, exp_q[i]); end
      else if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid byte %0d: got %h need %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - done_base != 1) begin errors++; $display("FAIL reset_mid pkt_done: got %0d need 1", done_cnt - done_base); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_slow_take();
    test_empty_flush();
    test_row_end_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
